// File: rtl/alu_reservation_station_pkg.sv
// Shared sizing, ALU op encodings and entry layout for the ALU reservation station.
// Also provides the CDB operand-capture helper used at dispatch and snoop.
package alu_reservation_station_pkg;

  localparam int unsigned RS_SIZE        = 8;
  localparam int unsigned RS_SIZE_WIDTH  = 3;
  localparam int unsigned ROB_SIZE_WIDTH = 4;
  localparam int unsigned XLEN           = 32;
  localparam int unsigned OP_WIDTH       = 5;

  // op[4] = branch compare, op[3] = sub/sra variant, op[2:0] = funct
  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD  = 5'b00000,
    OP_SLL  = 5'b00001,
    OP_SLT  = 5'b00010,
    OP_SLTU = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_SRL  = 5'b00101,
    OP_OR   = 5'b00110,
    OP_AND  = 5'b00111,
    OP_SUB  = 5'b01000,
    OP_SRA  = 5'b01101,
    OP_BEQ  = 5'b10000,
    OP_BNE  = 5'b10001,
    OP_BLT  = 5'b10100,
    OP_BGE  = 5'b10101,
    OP_BLTU = 5'b10110,
    OP_BGEU = 5'b10111
  } alu_op_e;

  typedef struct packed {
    logic                      has_q;
    logic [XLEN-1:0]           v;
  } operand_t;

  typedef struct packed {
    logic                      busy;
    logic [OP_WIDTH-1:0]       op;
    logic [XLEN-1:0]           vj;
    logic [XLEN-1:0]           vk;
    logic                      has_qj;
    logic                      has_qk;
    logic [ROB_SIZE_WIDTH-1:0] qj;
    logic [ROB_SIZE_WIDTH-1:0] qk;
    logic [ROB_SIZE_WIDTH-1:0] rob_id;
  } rs_entry_t;

  // Capture a pending operand from whichever CDB carries its tag; ALU bus checked first.
  function automatic operand_t snoop_operand(
    input logic                      has_q,
    input logic [ROB_SIZE_WIDTH-1:0] q,
    input logic [XLEN-1:0]           v,
    input logic                      a_valid,
    input logic [ROB_SIZE_WIDTH-1:0] a_tag,
    input logic [XLEN-1:0]           a_value,
    input logic                      l_valid,
    input logic [ROB_SIZE_WIDTH-1:0] l_tag,
    input logic [XLEN-1:0]           l_value
  );
    operand_t r;
    r.has_q = has_q;
    r.v     = v;
    if (has_q && a_valid && (q == a_tag)) begin
      r.has_q = 1'b0;
      r.v     = a_value;
    end else if (has_q && l_valid && (q == l_tag)) begin
      r.has_q = 1'b0;
      r.v     = l_value;
    end
    return r;
  endfunction

endpackage

// File: rtl/lowest_one_enc.sv
// Priority encoder: index of the lowest set bit plus a found flag.
module lowest_one_enc #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx_c,
  output logic         found_c
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx_c   = W'(i);
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ops until operands resolve via CDB snoop,
// then issues the lowest-index ready entry to the ALU through registered outputs.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      disp_valid,
  input  logic [OP_WIDTH-1:0]       disp_op,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_rob_id,
  input  logic [XLEN-1:0]           disp_vj,
  input  logic [XLEN-1:0]           disp_vk,
  input  logic                      disp_has_qj,
  input  logic                      disp_has_qk,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_qj,
  input  logic [ROB_SIZE_WIDTH-1:0] disp_qk,
  input  logic                      alu_cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_cdb_rob_id,
  input  logic [XLEN-1:0]           alu_cdb_value,
  input  logic                      lsb_cdb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_cdb_rob_id,
  input  logic [XLEN-1:0]           lsb_cdb_value,
  output logic                      full,
  output logic                      alu_valid,
  output logic [OP_WIDTH-1:0]       alu_op,
  output logic [XLEN-1:0]           alu_v1,
  output logic [XLEN-1:0]           alu_v2,
  output logic [ROB_SIZE_WIDTH-1:0] alu_rob_id
);

  localparam int unsigned CNT_WIDTH = RS_SIZE_WIDTH + 1;

  rs_entry_t                ent_q [RS_SIZE];
  rs_entry_t                ent_d [RS_SIZE];
  logic [RS_SIZE-1:0]       free_vec_c;
  logic [RS_SIZE-1:0]       ready_vec_c;
  logic [RS_SIZE_WIDTH-1:0] free_idx_c;
  logic [RS_SIZE_WIDTH-1:0] issue_idx_c;
  logic                     free_found_c;
  logic                     issue_found_c;
  logic                     disp_fire_c;
  operand_t                 new_j_c;
  operand_t                 new_k_c;
  logic [CNT_WIDTH-1:0]     count_q;
  logic [CNT_WIDTH-1:0]     count_d;

  // Slot selection works purely on registered state, so freed slots wait a cycle.
  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      free_vec_c[i]  = !ent_q[i].busy;
      ready_vec_c[i] = ent_q[i].busy && !ent_q[i].has_qj && !ent_q[i].has_qk;
    end
  end

  lowest_one_enc #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) u_free_enc (
    .vec     (free_vec_c),
    .idx_c   (free_idx_c),
    .found_c (free_found_c)
  );

  lowest_one_enc #(.N(RS_SIZE), .W(RS_SIZE_WIDTH)) u_ready_enc (
    .vec     (ready_vec_c),
    .idx_c   (issue_idx_c),
    .found_c (issue_found_c)
  );

  always_comb begin
    disp_fire_c = disp_valid && !full && free_found_c;
    new_j_c = snoop_operand(disp_has_qj, disp_qj, disp_vj,
                            alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
                            lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
    new_k_c = snoop_operand(disp_has_qk, disp_qk, disp_vk,
                            alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
                            lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].busy) begin
        {ent_d[i].has_qj, ent_d[i].vj} = snoop_operand(ent_q[i].has_qj, ent_q[i].qj, ent_q[i].vj,
            alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
            lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
        {ent_d[i].has_qk, ent_d[i].vk} = snoop_operand(ent_q[i].has_qk, ent_q[i].qk, ent_q[i].vk,
            alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value,
            lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value);
      end
    end
    if (issue_found_c) begin
      ent_d[issue_idx_c].busy = 1'b0;
    end
    if (disp_fire_c) begin
      ent_d[free_idx_c].busy   = 1'b1;
      ent_d[free_idx_c].op     = disp_op;
      ent_d[free_idx_c].vj     = new_j_c.v;
      ent_d[free_idx_c].vk     = new_k_c.v;
      ent_d[free_idx_c].has_qj = new_j_c.has_q;
      ent_d[free_idx_c].has_qk = new_k_c.has_q;
      ent_d[free_idx_c].qj     = disp_qj;
      ent_d[free_idx_c].qk     = disp_qk;
      ent_d[free_idx_c].rob_id = disp_rob_id;
    end
    count_d = count_q + CNT_WIDTH'(disp_fire_c) - CNT_WIDTH'(issue_found_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i] <= '0;
      end
      count_q    <= '0;
      full       <= 1'b0;
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_v1     <= '0;
      alu_v2     <= '0;
      alu_rob_id <= '0;
    end else if (clear) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent_q[i].busy <= 1'b0;
      end
      count_q   <= '0;
      full      <= 1'b0;
      alu_valid <= 1'b0;
    end else if (rdy) begin
      assert (!(disp_valid && full)) else $warning("dispatch attempted while full");
      ent_q     <= ent_d;
      count_q   <= count_d;
      full      <= (count_d == CNT_WIDTH'(RS_SIZE));
      alu_valid <= issue_found_c;
      if (issue_found_c) begin
        alu_op     <= ent_q[issue_idx_c].op;
        alu_v1     <= ent_q[issue_idx_c].vj;
        alu_v2     <= ent_q[issue_idx_c].vk;
        alu_rob_id <= ent_q[issue_idx_c].rob_id;
      end
    end
  end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station in front of the single-cycle ALU. It buffers dispatched integer and branch-compare ops until both operands are available, snooping the ALU and LSB result buses. Each cycle it issues at most one ready entry to the ALU as registered outputs. It sits between the decoder/dispatch stage and the ALU, and is flushed by the ROB on misprediction.

Parameters:
RS_SIZE, 8, number of entries (power of two)
RS_SIZE_WIDTH, 3, log2(RS_SIZE)
ROB_SIZE_WIDTH, 4, width of ROB tags (shared value in config.v)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = freeze all state and outputs
clear  in  1  ROB flush; drop all entries
disp_valid  in  1  dispatch request this cycle
disp_op  in  5  ALU op code (op[4]=branch compare, op[3]=sub/sra, op[2:0]=funct)
disp_rob_id  in  ROB_SIZE_WIDTH  destination ROB tag
disp_vj, disp_vk  in  32 each  operand values, valid when the matching has_q is 0
disp_has_qj, disp_has_qk  in  1 each  operand still pending
disp_qj, disp_qk  in  ROB_SIZE_WIDTH each  producer tags
alu_cdb_valid, alu_cdb_rob_id, alu_cdb_value  in  1/ROB_SIZE_WIDTH/32  ALU result broadcast
lsb_cdb_valid, lsb_cdb_rob_id, lsb_cdb_value  in  1/ROB_SIZE_WIDTH/32  load result broadcast
full  out  1  no free entry (registered-state view)
alu_valid  out  1  issue strobe to ALU
alu_op  out  5  issued op
alu_v1, alu_v2  out  32 each  issued operands
alu_rob_id  out  ROB_SIZE_WIDTH  issued ROB tag

Behaviour:
- Reset, checked first: all entries not busy. full=0, alu_valid=0, alu_op=0, alu_v1=0, alu_v2=0, alu_rob_id=0.
- Priority: rst > clear > !rdy > normal operation.
- clear: all busy bits cleared and alu_valid=0 on the next edge. Dispatch in the same cycle is dropped.
- !rdy: no state change and outputs hold, including alu_valid.
- Entry fields: busy, op, vj, vk, has_qj, has_qk, qj, qk, rob_id.
- Dispatch: when disp_valid and !full, write the lowest-index non-busy entry.
- Dispatch with full=1 is ignored. Dispatch must not be attempted when full; an assertion checks this.
- Same-cycle forwarding at dispatch: if has_qj and qj matches a valid CDB tag this cycle, store the CDB value and clear has_qj. Same rule for k. ALU bus is checked before LSB; the two never carry the same tag.
- Snoop: every busy entry with has_qX and qX equal to a valid CDB tag captures the value and clears has_qX on that edge.
- Ready entry: busy && !has_qj && !has_qk, using registered state. Entries that become ready by snoop this cycle are eligible next cycle.
- Issue: lowest-index ready entry. On the edge, alu_valid=1, alu_op/v1/v2/rob_id = that entry's fields, and the entry's busy is cleared. If none is ready, alu_valid=0 and the data outputs hold.
- Latency: dispatch with ready operands at edge N, alu_valid high after edge N+1, ALU result after edge N+2. A freshly dispatched entry never issues in its dispatch cycle.
- full = registered count of busy entries == RS_SIZE, updated each edge.
- Slot reuse: a slot freed by issue is not reused in the same cycle. Issue and dispatch in the same cycle leave the count unchanged.
- Operand order: v1=vj (rs1), v2=vk (rs2 or immediate, resolved by dispatch with has_qk=0).

Decomposition:
- config.v: RS_SIZE, RS_SIZE_WIDTH, ROB_SIZE_WIDTH, and ALU op code constants (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU), shared with the ALU and decoder.
- Sub-module lowest_one_enc (RS_SIZE-bit vector to index + found flag), instantiated twice: free-slot select and ready-slot select.

Test Plan:
- Ready dispatch: disp ADD vj=5 vk=7 rob=3, has_q=0 -> alu_valid=1 one edge later with op=ADD, v1=5, v2=7, alu_rob_id=3; entry freed.
- Dependency: disp SUB has_qj=1 qj=2 vk=1 rob=4; 3 cycles later lsb_cdb (rob 2, value 10) -> issue the cycle after capture with v1=10, v2=1, rob=4; no issue before the capture.
- Dispatch-cycle forwarding: disp with qk=6 while alu_cdb_valid rob 6 value 0xFFFF_FFFF -> entry stored ready; issue next edge with v2=0xFFFF_FFFF.
- Fill and ordering: 8 dispatches all waiting on tag 1 -> full=1 and a 9th dispatch is ignored; broadcast tag 1 -> 8 issues in index order 0..7 on consecutive cycles; full drops after the first issue.
- Flush and stall: rdy=0 for 3 cycles with a ready entry -> outputs frozen, no issue; then clear=1 -> no alu_valid afterwards, full=0, count 0.
- Reset mid-operation: rst with 5 busy entries and alu_valid=1 -> next edge all outputs 0 and entries empty; a subsequent dispatch issues normally.
